// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Contents:
//   DEFAULT_RESET_PC   - PC loaded on reset
//   DEFAULT_NOP_INSTR  - instruction presented to decode when nothing is buffered
//   fetch_entry_t      - {pc, instr} pair held in the fetch buffer
//   fetch_state_t      - fetch FSM states
//   align_pc()         - clears the low two bits of a redirect target
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, instr} entries sitting between instruction memory and decode.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   push        - write push_entry at the tail
//   push_entry  - entry to write
//   pop         - retire the head entry
//   flush       - discard all entries; wins over push and pop
//   full, empty - occupancy flags
//   count       - number of valid entries (0..DEPTH)
//   head        - oldest entry, read straight from storage
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A push into a full buffer is only taken when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction memory,
// buffers returned instructions and hands them to decode with a valid/ready handshake.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   PC_f            - registered fetch address to instruction memory
//   imem_read_en    - fetch enable to instruction memory (combinational)
//   Instruction_f   - instruction memory data for PC_f, same cycle
//   redirect_valid  - taken branch/jump; flushes the buffer and reloads the PC
//   redirect_pc     - redirect target (low two bits ignored)
//   halt_req        - stop fetching until the next redirect
//   dec_ready       - decode accepts the head entry this cycle
//   valid_d         - head entry valid
//   Instruction_d   - head instruction, NOP_INSTR when empty
//   PC_d            - head PC, 0 when empty
//   PC_plus4_d      - PC_d + 4
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] PC_f,
    output logic        imem_read_en,
    input  logic [31:0] Instruction_f,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    input  logic        dec_ready,
    output logic        valid_d,
    output logic [31:0] Instruction_d,
    output logic [31:0] PC_d,
    output logic [31:0] PC_plus4_d
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t  state;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic          buf_full;
    logic          buf_empty;
    logic [CW-1:0] buf_count;
    logic          pop;
    logic          space;

    assign valid_d = ~buf_empty;
    assign pop     = valid_d & dec_ready;
    assign space   = ~buf_full | pop;

    assign imem_read_en = ~rst & (state == FETCH) & ~halt_req & ~redirect_valid & space;

    assign push_entry = '{pc: PC_f, instr: Instruction_f};

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (imem_read_en),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .full       (buf_full),
        .empty      (buf_empty),
        .count      (buf_count),
        .head       (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            PC_f <= RESET_PC;
        end else if (redirect_valid) begin
            PC_f <= align_pc(redirect_pc);
        end else if (imem_read_en) begin
            PC_f <= PC_f + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else if (redirect_valid) begin
            state <= FETCH;
        end else if (state == FETCH && halt_req) begin
            state <= HALTED;
        end
    end

    always_comb begin
        Instruction_d = NOP_INSTR;
        PC_d          = 32'h0;
        if (valid_d) begin
            Instruction_d = head.instr;
            PC_d          = head.pc;
        end
    end

    assign PC_plus4_d = PC_d + 32'd4;

    // Occupancy flag and counter must never disagree.
    assert property (@(posedge clk) disable iff (rst) buf_empty == (buf_count == '0));

endmodule
